// File: rtl/rf_wport_arb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
// Contents: the rf write bus layout {we[37], waddr[36:32], wdata[31:0]},
// the FSM state encoding, and the STARVE_LIMIT default.
package rf_wport_arb_pkg;

  localparam int WADDR_W   = 5;
  localparam int WDATA_W   = 32;
  localparam int RF_BUS_W  = 1 + WADDR_W + WDATA_W;   // 38
  localparam int LU_ENT_W  = WADDR_W + WDATA_W;       // 37
  localparam int WE_BIT    = 37;
  localparam int WADDR_MSB = 36;
  localparam int WADDR_LSB = 32;
  localparam int WDATA_MSB = 31;
  localparam int WDATA_LSB = 0;

  localparam int unsigned DEF_STARVE_LIMIT = 8;

  // Arbiter states. IDLE: FIFO empty. PEND: FIFO holds entries, WB wins.
  // FORCE: one-cycle slot steal for a starved head.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PEND  = 2'd1;
  localparam logic [1:0] S_FORCE = 2'd2;

  typedef struct packed {
    logic               we;
    logic [WADDR_W-1:0] waddr;
    logic [WDATA_W-1:0] wdata;
  } rf_bus_t;

  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [WDATA_W-1:0] wdata;
  } lu_ent_t;

  function automatic logic [31:0] reg_onehot(input logic [WADDR_W-1:0] a);
    reg_onehot = 32'd1 << a;
  endfunction

endpackage

// File: rtl/rf_wport_arb_if.sv
// Bundle of the WB, long-latency-unit and register-file write signals.
// Latency: n/a (wiring only).
// Backpressure: lu_valid/lu_ready handshake; wb_hold stalls WB.
// Ports: wb_to_arb_bus, wb_hold, lu_valid, lu_ready, lu_waddr, lu_wdata,
// rf_wbus, pend_mask. master = pipeline side, slave = arbiter.
interface rf_wport_arb_if;
  import rf_wport_arb_pkg::*;

  rf_bus_t      wb_to_arb_bus;
  logic         wb_hold;
  logic         lu_valid;
  logic         lu_ready;
  logic [4:0]   lu_waddr;
  logic [31:0]  lu_wdata;
  rf_bus_t      rf_wbus;
  logic [31:0]  pend_mask;

  modport master (
    output wb_to_arb_bus, lu_valid, lu_waddr, lu_wdata,
    input  wb_hold, lu_ready, rf_wbus, pend_mask
  );

  modport slave (
    input  wb_to_arb_bus, lu_valid, lu_waddr, lu_wdata,
    output wb_hold, lu_ready, rf_wbus, pend_mask
  );

endinterface

// File: rtl/rf_wport_arb_fifo2.sv
// Two-entry FIFO holding long-latency results {waddr, wdata}.
// Latency: a pushed entry is visible at the head on the next cycle.
// Backpressure: o_full; push while full and pop while empty are ignored.
// Ports: i_push/i_push_dat, i_pop, o_full, o_empty, o_head_dat, and per-entry
// valid/address taps (o_ent_vld, o_ent_addr) for the pending-write mask.
module wport_fifo2
  import rf_wport_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_push,
  input  lu_ent_t               i_push_dat,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic                  o_empty,
  output lu_ent_t               o_head_dat,
  output logic [1:0]            o_ent_vld,
  output logic [1:0][WADDR_W-1:0] o_ent_addr
);

  logic [LU_ENT_W-1:0] r_mem [2];
  logic [1:0]          r_vld;
  logic                r_wptr;
  logic                r_rptr;
  logic                w_push;
  logic                w_pop;

  assign o_full  = &r_vld;
  assign o_empty = ~|r_vld;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_vld    <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_dat;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      // Push and pop never target the same slot: that would need the FIFO
      // to be empty (no pop) or full (no push).
      for (int i = 0; i < 2; i++) begin
        if (w_push && (r_wptr == 1'(i))) begin
          r_vld[i] <= 1'b1;
        end else if (w_pop && (r_rptr == 1'(i))) begin
          r_vld[i] <= 1'b0;
        end
      end
    end
  end

  assign o_head_dat    = r_mem[r_rptr];
  assign o_ent_vld     = r_vld;
  assign o_ent_addr[0] = r_mem[0][LU_ENT_W-1:WDATA_W];
  assign o_ent_addr[1] = r_mem[1][LU_ENT_W-1:WDATA_W];

endmodule

// File: rtl/rf_wport_arb.sv
// Arbitrates the single RF write port between WB and buffered mul/div results.
// Latency: WB writes same cycle; a buffered result writes at the earliest the
// cycle after its push. Backpressure: lu_ready low when the 2-entry FIFO is full;
// wb_hold stalls WB for one cycle when a starved head steals the slot.
// Ports: clk, resetn (async active-low), bus (rf_wport_arb_if.slave).
// Optional build macro WPORT_STARVE_EN: age counter + FORCE state; without it
// wb_hold is tied low and the FIFO drains only in WB-idle cycles.
module rf_wport_arb
  import rf_wport_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic           clk,
  input  logic           resetn,
  rf_wport_arb_if.slave  bus
);

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_starve_limit
    $error("rf_wport_arb: STARVE_LIMIT must be in 1..15");
  end

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [RF_BUS_W-1:0]     w_wb;
  logic [RF_BUS_W-1:0]     w_rf;
  logic                    w_wb_wr;
  logic                    w_lu_push;
  lu_ent_t                 w_lu_ent;
  logic                    w_pop;
  logic                    w_force;
  logic                    w_drain;
  logic                    w_full;
  logic                    w_empty;
  lu_ent_t                 w_head;
  logic [1:0]              w_ent_vld;
  logic [1:0][WADDR_W-1:0] w_ent_addr;
  logic [31:0]             w_pend_mask;

  assign w_wb = bus.wb_to_arb_bus;

  // r0 writes are dropped at the source. WB is also masked during reset so
  // the write port stays quiet while resetn is low.
  assign w_wb_wr   = resetn && w_wb[WE_BIT] && (w_wb[WADDR_MSB:WADDR_LSB] != '0);
  // An r0 result completes the handshake but is never stored.
  assign w_lu_push = bus.lu_valid && !w_full && (bus.lu_waddr != '0);
  assign w_lu_ent  = '{waddr: bus.lu_waddr, wdata: bus.lu_wdata};

`ifdef WPORT_STARVE_EN
  localparam logic [3:0] LIMIT_Q = 4'(STARVE_LIMIT);

  logic [3:0] r_age;
  logic [3:0] w_age_inc;
  logic       w_age_due;

  assign w_force   = (r_state == S_FORCE);
  assign w_age_inc = r_age + 4'd1;
  // Head has waited LIMIT cycles once this unpopped PEND cycle completes.
  assign w_age_due = (w_age_inc >= LIMIT_Q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_age <= '0;
    end else if (w_pop) begin
      r_age <= '0;
    end else if (r_state == S_PEND) begin
      r_age <= w_age_inc;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  // In PEND the head takes any slot WB leaves unused; FORCE always takes it.
  assign w_pop = !w_empty && (w_force || ((r_state == S_PEND) && !w_wb_wr));

  // The pop empties the FIFO: exactly one valid entry and nothing arriving.
  assign w_drain = w_pop && !w_lu_push && (w_ent_vld[0] ^ w_ent_vld[1]);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_lu_push) begin
          w_state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        if (w_drain) begin
          w_state_nxt = S_IDLE;
        end
`ifdef WPORT_STARVE_EN
        else if (!w_pop && w_age_due) begin
          w_state_nxt = S_FORCE;
        end
`endif
      end
      S_FORCE: begin
        w_state_nxt = w_drain ? S_IDLE : S_PEND;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  wport_fifo2 u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .i_push     (w_lu_push),
    .i_push_dat (w_lu_ent),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head_dat (w_head),
    .o_ent_vld  (w_ent_vld),
    .o_ent_addr (w_ent_addr)
  );

  // One source at most: the popped head, else a WB write, else nothing.
  always_comb begin
    w_rf = '0;
    if (w_pop) begin
      w_rf[WE_BIT]              = 1'b1;
      w_rf[WADDR_MSB:WADDR_LSB] = w_head.waddr;
      w_rf[WDATA_MSB:WDATA_LSB] = w_head.wdata;
    end else if (w_wb_wr) begin
      w_rf = w_wb;
    end
  end

  // Built from stored entries only; an incoming push shows up a cycle later.
  always_comb begin
    w_pend_mask = '0;
    for (int i = 0; i < 2; i++) begin
      if (w_ent_vld[i]) begin
        w_pend_mask = w_pend_mask | reg_onehot(w_ent_addr[i]);
      end
    end
  end

  assign bus.rf_wbus   = w_rf;
  assign bus.wb_hold   = w_force;
  assign bus.lu_ready  = !w_full;
  assign bus.pend_mask = w_pend_mask;

endmodule
